// File: rtl/sdf_flow_sched.sv
// -----------------------------------------------------------------------------
// sdf_flow_sched
// Round-robin scheduler that time-shares one single-port SDF actor among NFLOW
// first-word-fall-through input FIFOs. A grant is held for exactly one firing
// of RATE tokens, so the actor never sees tokens of two flows mixed inside one
// accumulation. Tokens are forwarded unchanged and tagged with the flow index
// and an end-of-firing marker.
//
// Ports:
//   ck        clock, rising edge
//   rst       asynchronous active-high reset
//   in_data   packed FIFO heads, flow i at [i*WIDTH +: WIDTH]
//   in_empty  per-flow FIFO empty flags
//   in_read   per-flow read strobe (one-hot or zero)
//   out_data  forwarded token (0 when wr is low)
//   out_flow  index of the granted flow
//   out_last  marks the RATE-th token of a firing (only with wr)
//   wr        write strobe toward the actor input FIFO
//   full      actor input FIFO full
//   busy      a grant is currently held
// -----------------------------------------------------------------------------
module sdf_flow_sched #(
   parameter int WIDTH = 32,
   parameter int NFLOW = 4,
   parameter int RATE  = 4,
   localparam int IDW  = (NFLOW > 1) ? $clog2(NFLOW) : 1,
   localparam int CW   = (RATE > 1) ? $clog2(RATE) : 1
) (
   input  logic                   ck,
   input  logic                   rst,
   input  logic [NFLOW*WIDTH-1:0] in_data,
   input  logic [NFLOW-1:0]       in_empty,
   output logic [NFLOW-1:0]       in_read,
   output logic [WIDTH-1:0]       out_data,
   output logic [IDW-1:0]         out_flow,
   output logic                   out_last,
   output logic                   wr,
   input  logic                   full,
   output logic                   busy
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t           state_reg, state_next;
   logic [IDW-1:0]   grant_reg, grant_next;
   logic [CW-1:0]    cnt_reg,   cnt_next;
   logic [IDW-1:0]   ptr_reg,   ptr_next;

   logic [WIDTH-1:0] flow_data [NFLOW];
   logic             pick_found;
   logic [IDW-1:0]   pick_idx;
   logic             xfer;
   logic             last_tok;

   // Unpack the FIFO heads so the granted one can be selected by index.
   generate
      for (genvar gi = 0; gi < NFLOW; gi++) begin : g_unpack
         assign flow_data[gi] = in_data[gi*WIDTH +: WIDTH];
         assign in_read[gi]   = xfer && (grant_reg == IDW'(gi));
      end
   endgenerate

   // Round-robin search starting just after the last-served flow. The loop
   // runs from the farthest candidate to the nearest so that the nearest
   // non-empty flow is the one left in pick_idx.
   always_comb begin
      int idx;
      pick_found = 1'b0;
      pick_idx   = '0;
      idx        = 0;
      for (int k = NFLOW; k >= 1; k--) begin
         idx = (int'(ptr_reg) + k) % NFLOW;
         if (!in_empty[idx]) begin
            pick_found = 1'b1;
            pick_idx   = IDW'(idx);
         end
      end
   end

   // A token moves only while a grant is held, the granted FIFO has data and
   // the actor FIFO has room; other flows are not looked at during a burst.
   assign xfer     = (state_reg == ST_BURST) && !in_empty[grant_reg] && !full;
   assign last_tok = xfer && (cnt_reg == CW'(RATE - 1));

   always_comb begin
      state_next = state_reg;
      grant_next = grant_reg;
      cnt_next   = cnt_reg;
      ptr_next   = ptr_reg;
      case (state_reg)
         ST_IDLE: begin
            if (pick_found) begin
               grant_next = pick_idx;
               cnt_next   = '0;
               state_next = ST_BURST;
            end
         end
         ST_BURST: begin
            if (xfer) begin
               if (last_tok) begin
                  cnt_next   = '0;
                  ptr_next   = grant_reg;
                  state_next = ST_IDLE;
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ptr resets to the last flow so that flow 0 is searched first.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         grant_reg <= '0;
         cnt_reg   <= '0;
         ptr_reg   <= IDW'(NFLOW - 1);
      end else begin
         state_reg <= state_next;
         grant_reg <= grant_next;
         cnt_reg   <= cnt_next;
         ptr_reg   <= ptr_next;
      end
   end

   assign wr       = xfer;
   assign out_last = last_tok;
   assign out_data = xfer ? flow_data[grant_reg] : '0;
   assign out_flow = grant_reg;
   assign busy     = (state_reg == ST_BURST);

endmodule

// File: doc/sdf_flow_sched.md
# sdf_flow_sched

Round-robin scheduler that time-shares one single-port SDF actor among `NFLOW` input FIFOs. Each grant is locked for exactly one firing of `RATE` tokens, so actor accumulations never mix flows, and no flow is starved. The scheduler sits between the producer-side FIFOs and the actor's input FIFO port. It forwards the granted flow's tokens unchanged and tags each token with its flow index and an end-of-firing marker.

## Interface
- `WIDTH`, 32 — token width in bits.
- `NFLOW`, 4 — number of input flows, 2..16.
- `RATE`, 4 — tokens per firing (SDF consumption rate), 2..256.
- `IDW`, derived = max(1, clog2(NFLOW)) — flow-index width.
- `CW`, derived = max(1, clog2(RATE)) — token-counter width.

Ports:
- `ck` input 1 — clock; all state changes on its rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `in_data` input NFLOW*WIDTH — packed FWFT FIFO heads; flow i occupies bits [i*WIDTH +: WIDTH].
- `in_empty` input NFLOW — per-flow FIFO empty.
- `in_read` output NFLOW — per-flow read strobe; at most one bit high.
- `out_data` output WIDTH — forwarded token; 0 when `wr`=0.
- `out_flow` output IDW — index of the granted flow.
- `out_last` output 1 — high together with `wr` on the RATE-th token of a firing.
- `wr` output 1 — write strobe to the downstream actor FIFO.
- `full` input 1 — downstream FIFO full.
- `busy` output 1 — high while a grant is held (state BURST).

## Operation
- **State machine.** Two states: IDLE and BURST. Registers: `state`, `grant` (IDW), `cnt` (CW), `ptr` (IDW, the last-served flow).
- **IDLE.**
  - Search flows `ptr+1, ptr+2, …` modulo NFLOW, wrapping past NFLOW-1 to 0.
  - Choose the first flow with `in_empty`=0. Load `grant`, clear `cnt`, go to BURST.
  - If every flow is empty, stay in IDLE.
  - No transfer happens in IDLE: `in_read`=0, `wr`=0.
- **BURST, transfer condition.** A transfer occurs when `xfer` = `in_empty[grant]`=0 and `full`=0. In that cycle:
  - `in_read[grant]`=1 and `wr`=1.
  - `out_data` = the `grant` slice of `in_data`.
  - `cnt` increments.
- **BURST, stall.**
  - If the granted flow is empty, or `full`=1, there is no transfer. The grant is held indefinitely, with no timeout and no pre-emption.
  - Other flows' empty flags are ignored during BURST.
- **BURST, end of firing.** On a transfer with `cnt`=RATE-1:
  - `out_last`=1.
  - `ptr` ← `grant`, `cnt` ← 0, next state IDLE.
- **Outputs.**
  - `out_flow` = `grant` at all times.
  - `busy` = (state == BURST).
  - `in_read`, `wr` and `out_last` are combinational from the registered state and the current `in_empty`/`full`.
- **Data path.** Tokens are never modified, widened or truncated.
- **Reset.**
  - State ← IDLE, `grant` ← 0, `cnt` ← 0, `ptr` ← NFLOW-1, so flow 0 has first priority after reset.
  - All outputs are 0 during and after reset until the first grant.
  - Reset asserted mid-burst abandons the partial firing. Tokens already written are not retracted; the downstream actor must also be reset.

## Timing
- **Arbitration.** One IDLE cycle precedes every firing. A flow going non-empty while the scheduler is IDLE is granted at the next edge. Its first `wr` can occur in the following cycle.
- **Throughput.** Best case is RATE transfers per RATE+1 cycles, one cycle per token inside a burst.
- **Read/write coupling.** `in_read` and `wr` are asserted in the same cycle as the data they qualify, with zero latency through the block. `wr` is never high while `full`=1.
- **Simultaneous events.** `full` rising during a cycle blocks that cycle's transfer. An empty flow refilling in the same cycle as `full` falls still transfers, provided both conditions hold in that cycle.
- **Fairness.** After a firing of flow k, every other non-empty flow is served before flow k is served again. Maximum wait is (NFLOW-1) firings.

## Test plan
- **Single flow.** Only flow 0 holds tokens 1,2,3,4; others empty; `full`=0.
  - `busy` rises 1 cycle after reset release.
  - 4 consecutive `wr`, `out_data` = 1,2,3,4, `out_flow`=0.
  - `out_last` high on token 4.
  - Back to IDLE.
- **Contention.** Flows 0 and 2 each hold 8 tokens.
  - Grant order: 0,2,0,2.
  - Each burst is exactly 4 `wr`; `out_flow` never changes mid-burst.
  - One idle cycle between bursts.
- **Downstream full.** Flow 1 bursting; `full`=1 for 3 cycles after token 2.
  - `wr`=0 and `in_read`=0 for those 3 cycles.
  - Tokens 3 and 4 follow once `full`=0, with no loss or duplication.
- **Granted flow empties.** Flow 3 holds 2 tokens while flow 0 holds 4.
  - Grant stays on 3 after 2 transfers; flow 0 is not read.
  - Pushing 2 more tokens to flow 3 completes the firing with `out_last`.
  - Flow 0 is granted next.
- **Wrap-around.** `ptr`=3 with flows 0 and 3 non-empty.
  - Flow 0 is granted before flow 3.
  - `ptr` wraps 3→0 with NFLOW=4.
- **Reset mid-burst.** Assert `rst` after token 2 of a flow-2 burst.
  - All outputs go to 0 immediately, asynchronously.
  - After release, flow 0 wins if non-empty, and `cnt` restarts at 0.
